// File: rtl/dcache_line_mover_if.sv
// Bus bundle between the line mover, the dcache data RAM and the memory side.
// master = line mover; slave = RAM / memory models. Names are from the mover's view.
interface dcache_line_mover_if #(
   parameter int line_amount = 64,
   parameter int line_size   = 16,
   parameter int data_width  = 32
);
   localparam int LW = $clog2(line_amount);
   localparam int WW = $clog2(line_size);
   localparam int SW = data_width / 8;

   logic                  ram_req_o;
   logic                  ram_wr_en_o;
   logic [LW-1:0]         ram_line_idx_o;
   logic [WW-1:0]         ram_word_idx_o;
   logic [data_width-1:0] ram_wdata_o;
   logic [SW-1:0]         ram_wstrb_o;
   logic [data_width-1:0] ram_rdata_i;
   logic                  fill_valid_i;
   logic                  fill_ready_o;
   logic [data_width-1:0] fill_data_i;
   logic                  wb_valid_o;
   logic                  wb_ready_i;
   logic [data_width-1:0] wb_data_o;
   logic                  wb_last_o;

   modport master (
      output ram_req_o, ram_wr_en_o, ram_line_idx_o, ram_word_idx_o,
      output ram_wdata_o, ram_wstrb_o, fill_ready_o,
      output wb_valid_o, wb_data_o, wb_last_o,
      input  ram_rdata_i, fill_valid_i, fill_data_i, wb_ready_i
   );

   modport slave (
      input  ram_req_o, ram_wr_en_o, ram_line_idx_o, ram_word_idx_o,
      input  ram_wdata_o, ram_wstrb_o, fill_ready_o,
      input  wb_valid_o, wb_data_o, wb_last_o,
      output ram_rdata_i, fill_valid_i, fill_data_i, wb_ready_i
   );
endinterface

// File: rtl/dcache_line_mover.sv
// Moves one dcache line: refill (memory -> data RAM) or writeback (data RAM -> memory).
// Ports: clk_i, rst_ni (sync, active-low), start_i/op_i/line_i request, busy_o/done_o status, bus = RAM/fill/wb bundle.
module dcache_line_mover #(
   parameter int line_amount = 64,
   parameter int line_size   = 16,
   parameter int data_width  = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic                           op_i,
   input  logic [$clog2(line_amount)-1:0] line_i,
   output logic                           busy_o,
   output logic                           done_o,
   dcache_line_mover_if.master            bus
);
   localparam int LW = $clog2(line_amount);
   localparam int WW = $clog2(line_size);
   localparam int DW = data_width;
   localparam logic [WW:0]   RD_END = (WW+1)'(line_size);
   localparam logic [WW-1:0] LAST_W = WW'(line_size - 1);

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WB, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [LW-1:0]       line_q, line_d;
   logic [WW:0]         cnt_q, cnt_d;
   logic [WW-1:0]       sent_q, sent_d;
   logic                inflight_q, inflight_d;
   logic [1:0][DW-1:0]  fifo_q, fifo_d;
   logic [1:0]          fcnt_q, fcnt_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic                wr_ptr_q, wr_ptr_d;

   logic          wb_valid;
   logic          pop;
   logic          pop_stored;
   logic          push;
   logic          req;
   logic [DW-1:0] head;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         line_q     <= '0;
         cnt_q      <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         fifo_q     <= '0;
         fcnt_q     <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         cnt_q      <= cnt_d;
         sent_q     <= sent_d;
         inflight_q <= inflight_d;
         fifo_q     <= fifo_d;
         fcnt_q     <= fcnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      cnt_d      = cnt_q;
      sent_d     = sent_q;
      inflight_d = 1'b0;
      fifo_d     = fifo_q;
      fcnt_d     = fcnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      wb_valid   = 1'b0;
      pop        = 1'b0;
      pop_stored = 1'b0;
      push       = 1'b0;
      req        = 1'b0;
      head       = '0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      bus.ram_req_o      = 1'b0;
      bus.ram_wr_en_o    = 1'b0;
      bus.ram_line_idx_o = line_q;
      bus.ram_word_idx_o = '0;
      bus.ram_wdata_o    = '0;
      bus.ram_wstrb_o    = '0;
      bus.fill_ready_o   = 1'b0;
      bus.wb_valid_o     = 1'b0;
      bus.wb_data_o      = '0;
      bus.wb_last_o      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               line_d  = line_i;
               cnt_d   = '0;
               sent_d  = '0;
               state_d = op_i ? S_WB : S_REFILL;
            end
         end
         S_REFILL: begin
            busy_o             = 1'b1;
            bus.fill_ready_o   = 1'b1;
            bus.ram_word_idx_o = cnt_q[WW-1:0];
            bus.ram_wdata_o    = bus.fill_data_i;
            if (bus.fill_valid_i) begin
               bus.ram_wr_en_o = 1'b1;
               bus.ram_wstrb_o = '1;
               cnt_d           = cnt_q + (WW+1)'(1);
               if (cnt_q[WW-1:0] == LAST_W) state_d = S_DONE;
            end
         end
         S_WB: begin
            busy_o = 1'b1;
            // The word returning from the RAM this cycle is visible at the
            // head when the FIFO is empty, so a pipelined read sustains one
            // beat per cycle with only two buffered words in total.
            wb_valid   = (fcnt_q != 2'd0) | inflight_q;
            head       = (fcnt_q != 2'd0) ? fifo_q[rd_ptr_q] : bus.ram_rdata_i;
            pop        = wb_valid & bus.wb_ready_i;
            pop_stored = pop & (fcnt_q != 2'd0);
            push       = inflight_q & ~(pop & (fcnt_q == 2'd0));
            req        = (cnt_q < RD_END) &&
                         ((fcnt_q + {1'b0, inflight_q}) < 2'd2);
            bus.wb_valid_o = wb_valid;
            bus.wb_data_o  = wb_valid ? head : '0;
            bus.wb_last_o  = wb_valid && (sent_q == LAST_W);
            if (push) begin
               fifo_d[wr_ptr_q] = bus.ram_rdata_i;
               wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop_stored) rd_ptr_d = ~rd_ptr_q;
            fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop_stored};
            if (req) begin
               bus.ram_req_o      = 1'b1;
               bus.ram_word_idx_o = cnt_q[WW-1:0];
               cnt_d              = cnt_q + (WW+1)'(1);
               inflight_d         = 1'b1;
            end
            if (pop) begin
               sent_d = sent_q + WW'(1);
               if (sent_q == LAST_W) state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule
